// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC date/time register sequencer.
//   state_t        - sequencer FSM states
//   RTC_BASE_ADDR  - bus address of the first date/time register (seconds)
//   IDX_*          - holding-register indices (seg, min, hora, dia, mes, anio)
//   NREG           - number of date/time registers sequenced
//   reg_addr()     - bus address of the register at a given index
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] RTC_BASE_ADDR = 8'h21;

  localparam logic [2:0] IDX_SEG  = 3'd0;
  localparam logic [2:0] IDX_MIN  = 3'd1;
  localparam logic [2:0] IDX_HORA = 3'd2;
  localparam logic [2:0] IDX_DIA  = 3'd3;
  localparam logic [2:0] IDX_MES  = 3'd4;
  localparam logic [2:0] IDX_ANIO = 3'd5;

  localparam int NREG = 6;

  function automatic logic [7:0] reg_addr(input logic [2:0] idx);
    return RTC_BASE_ADDR + {5'd0, idx};
  endfunction

endpackage

// File: rtl/rtc_seq_ctrl_if.sv
// rtc_seq_ctrl_if: request/acknowledge bus between the sequencer and the
// RTC bus interface.
//   bus_req   - access request (master -> slave)
//   bus_wr    - 1 = write, 0 = read (master -> slave)
//   bus_addr  - RTC register address (master -> slave)
//   bus_wdata - write data (master -> slave)
//   bus_ack   - access complete (slave -> master)
//   bus_rdata - read data, valid with bus_ack on reads (slave -> master)
interface rtc_seq_ctrl_if;

  logic       bus_req;
  logic       bus_wr;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_ack;
  logic [7:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/rtc_ack_timer.sv
// rtc_ack_timer: 8-bit acknowledge timeout counter.
//   clk, reset - clock and synchronous active-high reset
//   load       - clear the count (asserted the cycle before waiting starts)
//   count_en   - advance the count (asserted every waiting cycle)
//   expire     - this waiting cycle is the last one allowed
module rtc_ack_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count_en,
  output logic expire
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (count_en) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // The count holds the number of waiting cycles already spent; flagging at
  // TIMEOUT-1 means the count reaches TIMEOUT on the edge that leaves the
  // wait, i.e. exactly TIMEOUT waiting cycles are granted.
  assign expire = count_en && !load && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/rtc_seq_ctrl.sv
// rtc_seq_ctrl: sequences reads or writes of the NREG RTC date/time
// registers over a request/acknowledge bus.
//   clk, reset - clock and synchronous active-high reset
//   start_rd   - pulse: read all RTC registers into the holding registers
//   start_wr   - pulse: write all holding registers to the RTC (wins over start_rd)
//   reg_q      - holding-register value selected by sel
//   bus        - master side of rtc_seq_ctrl_if (req/wr/addr/wdata, ack/rdata)
//   sel        - index of the register being handled
//   en_reg     - one-hot holding-register load enable (LOAD cycle only)
//   dato_out   - data for the holding registers, valid with en_reg
//   busy       - sequence in progress
//   done, err  - one-cycle completion / timeout pulses
module rtc_seq_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int NREG    = rtc_pkg::NREG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic [7:0]        reg_q,
  rtc_seq_ctrl_if.master    bus,
  output logic [2:0]        sel,
  output logic [NREG-1:0]   en_reg,
  output logic [7:0]        dato_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import rtc_pkg::*;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       wr_q, wr_d;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;

  logic       tmr_load;
  logic       tmr_en;
  logic       tmr_expire;

  logic       last_idx;
  state_t     state_adv;
  logic [2:0] idx_adv;

  assign last_idx  = (idx_q == 3'(NREG - 1));
  assign state_adv = last_idx ? ST_DONE : ST_ISSUE;
  assign idx_adv   = last_idx ? idx_q : idx_q + 3'd1;

  rtc_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .count_en (tmr_en),
    .expire   (tmr_expire)
  );

  // Control state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
    end
  end

  // Data captures: write byte is frozen at issue so a changing reg_q cannot
  // disturb an access in flight; read byte is taken with the acknowledge.
  always_ff @(posedge clk) begin
    if (state_q == ST_ISSUE) begin
      wdata_q <= reg_q;
    end
    if (state_q == ST_WAIT_ACK && bus.bus_ack && !wr_q) begin
      rdata_q <= bus.bus_rdata;
    end
  end

  // Next state
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_wr) begin
          state_d = ST_ISSUE;
          idx_d   = '0;
          wr_d    = 1'b1;
        end else if (start_rd) begin
          state_d = ST_ISSUE;
          idx_d   = '0;
          wr_d    = 1'b0;
        end
      end
      ST_ISSUE: begin
        state_d  = ST_WAIT_ACK;
        tmr_load = 1'b1;
      end
      ST_WAIT_ACK: begin
        tmr_en = 1'b1;
        // An acknowledge on the last allowed cycle still completes the access.
        if (bus.bus_ack) begin
          if (wr_q) begin
            state_d = state_adv;
            idx_d   = idx_adv;
          end else begin
            state_d = ST_LOAD;
          end
        end else if (tmr_expire) begin
          state_d = ST_ERR;
        end
      end
      ST_LOAD: begin
        state_d = state_adv;
        idx_d   = idx_adv;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: everything is decoded from the state so that reset, which
  // forces IDLE, returns every output to zero on the following cycle.
  always_comb begin
    bus.bus_req   = 1'b0;
    bus.bus_wr    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    sel           = '0;
    en_reg        = '0;
    dato_out      = '0;
    busy          = (state_q != ST_IDLE);
    done          = 1'b0;
    err           = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        bus.bus_req   = 1'b1;
        bus.bus_wr    = wr_q;
        bus.bus_addr  = reg_addr(idx_q);
        bus.bus_wdata = wr_q ? reg_q : 8'd0;
        sel           = idx_q;
      end
      ST_WAIT_ACK: begin
        bus.bus_req   = 1'b1;
        bus.bus_wr    = wr_q;
        bus.bus_addr  = reg_addr(idx_q);
        bus.bus_wdata = wr_q ? wdata_q : 8'd0;
        sel           = idx_q;
      end
      ST_LOAD: begin
        sel      = idx_q;
        en_reg   = NREG'(1) << idx_q;
        dato_out = rdata_q;
      end
      ST_DONE: begin
        sel  = idx_q;
        done = 1'b1;
      end
      ST_ERR: begin
        sel = idx_q;
        err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/rtc_seq_ctrl.md
RTC_SEQ_CTRL -- requirements
Module: rtc_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles waited for bus_ack per access.
REQ-002 Parameter NREG, default 6, number of date/time holding registers sequenced.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 start_rd  in  1  one-cycle pulse: read all NREG RTC registers into holding registers.
REQ-006 start_wr  in  1  one-cycle pulse: write all NREG holding-register values to the RTC.
REQ-007 reg_q  in  8  holding-register value selected by sel (external mux, combinational).
REQ-008 bus_ack  in  1  RTC bus interface access complete; bus_rdata valid in the same cycle on reads.
REQ-009 bus_rdata  in  8  read data from RTC bus interface.
REQ-010 bus_req  out  1  access request to RTC bus interface.
REQ-011 bus_wr  out  1  1 = write access, 0 = read access.
REQ-012 bus_addr  out  8  RTC register address.
REQ-013 bus_wdata  out  8  write data.
REQ-014 sel  out  3  index of the current register: 0 seg, 1 min, 2 hora, 3 dia, 4 mes, 5 anio.
REQ-015 en_reg  out  6  one-hot load enable to the holding registers (bit i = index i).
REQ-016 dato_out  out  8  data for the holding registers, valid while any en_reg bit is high.
REQ-017 busy, done, err  out  1 each  sequence active / completion pulse / timeout pulse.

Function
REQ-018 States: IDLE, ISSUE, WAIT_ACK, LOAD, DONE, ERR.
REQ-019 IDLE: start_wr -> ISSUE with bus_wr=1; else start_rd -> ISSUE with bus_wr=0; index=0; start_wr wins on simultaneous pulses.
REQ-020 start_rd/start_wr are ignored when not in IDLE.
REQ-021 ISSUE: bus_req=1, bus_addr=0x21+index, bus_wdata=reg_q (write), sel=index; next state WAIT_ACK.
REQ-022 bus_req, bus_wr, bus_addr, bus_wdata held stable from ISSUE through the cycle where bus_ack=1; bus_req low the following cycle.
REQ-023 bus_ack is ignored when bus_req=0.
REQ-024 WAIT_ACK with bus_ack=1: read -> LOAD with bus_rdata latched; write -> next index.
REQ-025 LOAD: en_reg bit index high exactly one cycle, dato_out=latched byte; then next index.
REQ-026 Next index: index==NREG-1 -> DONE, else index+1 -> ISSUE.
REQ-027 DONE: done=1 one cycle, then IDLE.
REQ-028 Timeout counter (8 bits) cleared on entry to WAIT_ACK; reaching TIMEOUT without bus_ack -> ERR.
REQ-029 ERR: err=1 one cycle, bus_req=0, no further en_reg, then IDLE; already-loaded registers keep their values.
REQ-030 busy=1 in every state except IDLE.
REQ-031 Minimum access latency: ISSUE to ack = 2 cycles; full read with zero-wait ack = 1 + 6x3 + 1 cycles start-to-done.
REQ-032 en_reg never has more than one bit set; en_reg=0 outside LOAD.

Reset
REQ-033 reset in any state -> IDLE, index=0, timeout count=0, in the next cycle.
REQ-034 Reset values: bus_req=0, bus_wr=0, bus_addr=0, bus_wdata=0, sel=0, en_reg=0, dato_out=0, busy=0, done=0, err=0.
REQ-035 reset mid-access drops bus_req immediately; the aborted access issues no en_reg.

Structure
REQ-036 Shared package rtc_pkg holds the state enumeration, RTC_BASE_ADDR=0x21, the register index constants, and NREG.
REQ-037 A sub-module rtc_ack_timer (8-bit load/count/expire) is used for the timeout; everything else is flat.

Verification
REQ-038 start_rd, ack 1 cycle after each req, rdata 0x10..0x15 -> en_reg 000001..100000 in order, dato_out 0x10..0x15, done at cycle 20.
REQ-039 start_wr, reg_q = 0x30+sel -> six writes at addr 0x21..0x26 with wdata 0x30..0x35, no en_reg, done pulse.
REQ-040 start_rd and start_wr in the same cycle -> bus_wr=1 on the first access; a start_rd pulse mid-sequence is ignored.
REQ-041 No ack on index 3 (dia, addr 0x24) -> after 255 cycles err=1 one cycle, en_reg bits 0..2 pulsed only, busy=0 next cycle.
REQ-042 reset asserted during WAIT_ACK of index 2 -> all outputs at reset values next cycle; a later start_rd restarts at addr 0x21.
